// File: rtl/reorder_pkg.sv
// Shared defaults and state encoding for the reorder tag issuer.
package reorder_pkg;

  localparam int unsigned DefaultDw = 18;
  localparam int unsigned DefaultAw = 7;

  typedef enum logic {
    StRun,
    StDrain
  } issuer_state_e;

  // Next tag in the reorder window; wraps naturally at 2**AW.
  function automatic logic [31:0] tag_advance(input logic [31:0] tag, input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (tag + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter for the reorder window: counts issued-but-unretired entries,
// flags a full window and latches an underflow error until reset.
module credit_counter #(
  parameter int unsigned AW = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        dec_i,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        err_o
);

  localparam logic [AW:0] DepthCnt = {1'b1, {AW{1'b0}}};

  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    case ({inc_i, dec_i})
      2'b10: begin
        if (count_q != DepthCnt) begin
          count_d = count_q + 1'b1;
        end
      end
      2'b01: begin
        if (count_q == '0) begin
          err_d = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      2'b11: begin
        // Simultaneous issue and retire cancel; a retire against an empty window is still an error.
        if (count_q == '0) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
    full_d = (count_d == DepthCnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = full_q;
  assign err_o   = err_q;

endmodule

// File: rtl/reorder_tag_issuer.sv
// Issues upstream requests with sequential reorder tags, limited by a credit window of 2**AW
// entries; a drain request quiesces issue until every tag retires, then restarts tags at 0.
module reorder_tag_issuer
  import reorder_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned AW = DefaultAw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  input  logic [DW-1:0] req_data,
  output logic          req_rdy,
  output logic          iss_vld,
  output logic [DW-1:0] iss_data,
  output logic [AW-1:0] iss_tag,
  input  logic          iss_rdy,
  input  logic          retire,
  input  logic          drain_req,
  output logic [AW:0]   outstanding,
  output logic          win_full,
  output logic          drain_done,
  output logic          err
);

  issuer_state_e state_q, state_d;
  logic [AW-1:0] tag_q, tag_d;
  logic          iss_vld_q, iss_vld_d;
  logic [DW-1:0] iss_data_q, iss_data_d;
  logic [AW-1:0] iss_tag_q, iss_tag_d;
  logic          drain_done_q, drain_done_d;
  logic          accept;
  logic          drain_exit;

  // The single output stage may refill in the same cycle it is being consumed.
  always_comb begin
    req_rdy = !rst && (state_q == StRun) && !win_full && (!iss_vld_q || iss_rdy);
    accept  = req_vld && req_rdy;
  end

  assign drain_exit = (state_q == StDrain) && (outstanding == '0) && !iss_vld_q;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    drain_done_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (drain_req) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_exit) begin
          state_d      = StRun;
          tag_d        = '0;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
    if (accept) begin
      tag_d = tag_q + 1'b1;
    end
  end

  always_comb begin
    iss_vld_d  = iss_vld_q;
    iss_data_d = iss_data_q;
    iss_tag_d  = iss_tag_q;
    if (accept) begin
      iss_vld_d  = 1'b1;
      iss_data_d = req_data;
      iss_tag_d  = tag_q;
    end else if (iss_rdy) begin
      iss_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      tag_q        <= '0;
      iss_vld_q    <= 1'b0;
      iss_data_q   <= '0;
      iss_tag_q    <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      iss_vld_q    <= iss_vld_d;
      iss_data_q   <= iss_data_d;
      iss_tag_q    <= iss_tag_d;
      drain_done_q <= drain_done_d;
    end
  end

  credit_counter #(
    .AW(AW)
  ) u_credit_counter (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (accept),
    .dec_i   (retire),
    .count_o (outstanding),
    .full_o  (win_full),
    .err_o   (err)
  );

  assign iss_vld    = iss_vld_q;
  assign iss_data   = iss_data_q;
  assign iss_tag    = iss_tag_q;
  assign drain_done = drain_done_q;

endmodule
